// File: rtl/hazard_detection_unit_if.sv
// Hazard detection unit bundle: ID/EX/MEM operand information from the
// pipeline plus the stall/flush controls and performance counters returned
// to it. The pipeline side uses the master modport, the hazard unit uses
// the slave modport.
interface hazard_detection_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             use_rs2;
    logic             branch;
    logic             jalr;
    logic             branch_taken;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_regwrite;
    logic             ID_EX_memread;
    logic [4:0]       EX_MEM_rd;
    logic             EX_MEM_memread;
    logic             mem_stall;
    logic             pc_write;
    logic             IF_ID_write;
    logic             ID_EX_bubble;
    logic             IF_ID_flush;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, use_rs2, branch, jalr, branch_taken,
               ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
               EX_MEM_rd, EX_MEM_memread, mem_stall,
        input  pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze,
               stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, use_rs2, branch, jalr, branch_taken,
               ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
               EX_MEM_rd, EX_MEM_memread, mem_stall,
        output pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Detects hazards the bypass network cannot cover (load-use, and branch/JALR
// operands still in flight when resolved in ID), freezes PC and IF/ID,
// injects ID/EX bubbles, sequences the two-cycle branch-on-load stall and
// holds the whole pipe while the data cache is busy.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall/flush performance counters; otherwise both counter outputs are 0.
module hazard_detection_unit #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_detection_unit_if.slave hz
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL_X = 2'd1,
        ST_FREEZE  = 2'd2
    } state_e;

    state_e state_r;
    logic   saved_stall_x_r;   // return state of a freeze: 1 = STALL_X, 0 = IDLE
    state_e cur_s;             // state whose behaviour applies this cycle

    logic       use_rs2_eff_s;
    logic       resolve_s;
    logic       ex_hit_s;
    logic       mem_hit_s;
    logic [1:0] need_s;

    logic pc_write_s;
    logic if_id_write_s;
    logic id_ex_bubble_s;
    logic if_id_flush_s;
    logic pipe_freeze_s;

    // Producer rd matches a source of the ID instruction (x0 never matches).
    function automatic logic reg_match(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use2
    );
        return (rd != 5'd0) && ((rd == rs1) || (use2 && (rd == rs2)));
    endfunction

    // JALR only reads rs1, so its rs2 field never creates a dependency.
    assign use_rs2_eff_s = hz.use_rs2 & ~hz.jalr;
    assign resolve_s     = hz.branch | hz.jalr;
    assign ex_hit_s      = reg_match(hz.ID_EX_rd, hz.IF_ID_rs1, hz.IF_ID_rs2, use_rs2_eff_s);
    assign mem_hit_s     = reg_match(hz.EX_MEM_rd, hz.IF_ID_rs1, hz.IF_ID_rs2, use_rs2_eff_s);

    // Number of stall cycles the ID instruction needs before it can proceed.
    always_comb begin
        need_s = 2'd0;
        if (resolve_s && hz.ID_EX_memread && ex_hit_s) begin
            need_s = 2'd2;
        end else if (hz.ID_EX_memread && ex_hit_s) begin
            need_s = 2'd1;
        end else if (resolve_s && hz.ID_EX_regwrite && ex_hit_s) begin
            need_s = 2'd1;
        end else if (resolve_s && hz.EX_MEM_memread && mem_hit_s) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // On release from a freeze the cycle behaves as the saved state.
    always_comb begin
        cur_s = state_r;
        if (state_r == ST_FREEZE) begin
            cur_s = saved_stall_x_r ? ST_STALL_X : ST_IDLE;
        end else begin
            cur_s = state_r;
        end
    end

    // Stall/flush/freeze controls, combinational so hazards act in the same cycle.
    always_comb begin
        pc_write_s     = 1'b0;
        if_id_write_s  = 1'b0;
        id_ex_bubble_s = 1'b1;
        if_id_flush_s  = 1'b0;
        pipe_freeze_s  = 1'b0;
        if (rst) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else if (hz.mem_stall) begin
            id_ex_bubble_s = 1'b0;
            pipe_freeze_s  = 1'b1;
        end else begin
            case (cur_s)
                ST_STALL_X: begin
                    id_ex_bubble_s = 1'b1;
                end
                ST_IDLE: begin
                    if (need_s != 2'd0) begin
                        id_ex_bubble_s = 1'b1;
                    end else begin
                        pc_write_s     = 1'b1;
                        if_id_write_s  = 1'b1;
                        id_ex_bubble_s = 1'b0;
                        if_id_flush_s  = hz.branch_taken;
                    end
                end
                default: begin
                    id_ex_bubble_s = 1'b1;
                end
            endcase
        end
    end

    // FSM: sequences the extra branch-on-load stall and remembers where a freeze returns to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            saved_stall_x_r <= 1'b0;
        end else if (hz.mem_stall) begin
            state_r <= ST_FREEZE;
            if (state_r != ST_FREEZE) begin
                saved_stall_x_r <= (state_r == ST_STALL_X);
            end
        end else begin
            case (cur_s)
                ST_IDLE:    state_r <= (need_s == 2'd2) ? ST_STALL_X : ST_IDLE;
                ST_STALL_X: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    assign hz.pc_write     = pc_write_s;
    assign hz.IF_ID_write  = if_id_write_s;
    assign hz.ID_EX_bubble = id_ex_bubble_s;
    assign hz.IF_ID_flush  = if_id_flush_s;
    assign hz.pipe_freeze  = pipe_freeze_s;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating counts of lost cycles (bubble or freeze) and of IF/ID flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((id_ex_bubble_s || pipe_freeze_s) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (if_id_flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign hz.stall_cycles = stall_cnt_r;
    assign hz.flush_count  = flush_cnt_r;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios checked
// against constant expectations, then randomized traffic checked against a
// reference model that counts pending stall cycles.
module tb_hazard_detection_unit;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // Output vector order: {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_FLUSH = 5'b11010;
    localparam logic [4:0] O_FRZ   = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00100;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    hazard_detection_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_detection_unit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] get_out();
        return {hif.pc_write, hif.IF_ID_write, hif.ID_EX_bubble, hif.IF_ID_flush, hif.pipe_freeze};
    endfunction

    function automatic logic [2*CNT_W-1:0] get_cnt();
        return {hif.stall_cycles, hif.flush_count};
    endfunction

    function automatic logic [2*CNT_W-1:0] exp_cnt(input int s, input int f);
        logic [2*CNT_W-1:0] v;
`ifdef HAZARD_PERF_CNT_EN
        v = {s[CNT_W-1:0], f[CNT_W-1:0]};
`else
        v = {(2*CNT_W){1'b0}};
`endif
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, then let outputs settle.
    task automatic set_in(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
        input logic br, input logic jr, input logic tk,
        input logic [4:0] exrd, input logic exrw, input logic exmr,
        input logic [4:0] memrd, input logic memmr,
        input logic ms, input logic r
    );
        @(negedge clk);
        hif.IF_ID_rs1      = rs1;
        hif.IF_ID_rs2      = rs2;
        hif.use_rs2        = u2;
        hif.branch         = br;
        hif.jalr           = jr;
        hif.branch_taken   = tk;
        hif.ID_EX_rd       = exrd;
        hif.ID_EX_regwrite = exrw;
        hif.ID_EX_memread  = exmr;
        hif.EX_MEM_rd      = memrd;
        hif.EX_MEM_memread = memmr;
        hif.mem_stall      = ms;
        rst                = r;
        #1;
    endtask

    task automatic quiet(input logic tk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, tk, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (get_out() !== O_RST) begin
            n_fail++; $display("FAIL reset_outputs got %b want %b", get_out(), O_RST);
        end
        n_cmp++;
        if (get_cnt() !== exp_cnt(0, 0)) begin
            n_fail++; $display("FAIL reset_counters got %h want %h", get_cnt(), exp_cnt(0, 0));
        end
        quiet(1'b0);
        n_cmp++;
        if (get_out() !== O_RUN) begin
            n_fail++; $display("FAIL reset_release got %b want %b", get_out(), O_RUN);
        end
    endtask

    // EX = lw x5, ID = add x6,x5,x7
    task automatic test_load_use();
        set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_STALL) begin
            n_fail++; $display("FAIL load_use_stall got %b want %b", get_out(), O_STALL);
        end
        set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_RUN) begin
            n_fail++; $display("FAIL load_use_after got %b want %b", get_out(), O_RUN);
        end
    endtask

    // EX = lw x5, ID = beq x5,x0 (taken)
    task automatic test_branch_load();
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_STALL) begin
            n_fail++; $display("FAIL br_load_c1 got %b want %b", get_out(), O_STALL);
        end
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_STALL) begin
            n_fail++; $display("FAIL br_load_c2 got %b want %b", get_out(), O_STALL);
        end
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_FLUSH) begin
            n_fail++; $display("FAIL br_load_c3 got %b want %b", get_out(), O_FLUSH);
        end
    endtask

    // EX = addi x3,x3,1, ID = bne x3,x4; then x0 producer and jalr rs2 immunity
    task automatic test_branch_alu();
        set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_STALL) begin
            n_fail++; $display("FAIL br_alu_stall got %b want %b", get_out(), O_STALL);
        end
        set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_RUN) begin
            n_fail++; $display("FAIL br_alu_after got %b want %b", get_out(), O_RUN);
        end
        set_in(5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_FLUSH) begin
            n_fail++; $display("FAIL br_x0_producer got %b want %b", get_out(), O_FLUSH);
        end
        set_in(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_FLUSH) begin
            n_fail++; $display("FAIL jalr_rs2_ignored got %b want %b", get_out(), O_FLUSH);
        end
    endtask

    task automatic test_freeze();
        // Enter STALL_X, then freeze three cycles
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (get_out() !== O_FRZ) begin
                n_fail++; $display("FAIL freeze_sx_%0d got %b want %b", i, get_out(), O_FRZ);
            end
        end
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_STALL) begin
            n_fail++; $display("FAIL freeze_sx_resume got %b want %b", get_out(), O_STALL);
        end
        quiet(1'b0);
        n_cmp++;
        if (get_out() !== O_RUN) begin
            n_fail++; $display("FAIL freeze_sx_idle got %b want %b", get_out(), O_RUN);
        end
        // Freeze beats a simultaneous load-use; need re-evaluated on release
        set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (get_out() !== O_FRZ) begin
            n_fail++; $display("FAIL freeze_wins got %b want %b", get_out(), O_FRZ);
        end
        set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (get_out() !== O_STALL) begin
            n_fail++; $display("FAIL freeze_reeval got %b want %b", get_out(), O_STALL);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (get_out() !== O_RST) begin
            n_fail++; $display("FAIL rst_mid_sx got %b want %b", get_out(), O_RST);
        end
        quiet(1'b0);
        n_cmp++;
        if (get_out() !== O_RUN) begin
            n_fail++; $display("FAIL rst_mid_sx_release got %b want %b", get_out(), O_RUN);
        end
        n_cmp++;
        if (get_cnt() !== exp_cnt(0, 0)) begin
            n_fail++; $display("FAIL rst_mid_sx_counters got %h want %h", get_cnt(), exp_cnt(0, 0));
        end
    endtask

    task automatic test_perf();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            set_in(5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
            quiet(1'b0);
        end
        quiet(1'b1);
        quiet(1'b0);
        n_cmp++;
        if (get_cnt() !== exp_cnt(2, 1)) begin
            n_fail++; $display("FAIL perf_counters got %h want %h", get_cnt(), exp_cnt(2, 1));
        end
    endtask

    // Reference model: a count of stall cycles still owed by the ID instruction.
    function automatic int need_of(
        input int rs1, input int rs2, input bit u2, input bit br, input bit jr,
        input int exrd, input bit exrw, input bit exmr, input int memrd, input bit memmr
    );
        bit reads2;
        bit ex_dep;
        bit mem_dep;
        reads2  = u2 && !jr;
        ex_dep  = (exrd != 0) && (exrd == rs1 || (reads2 && exrd == rs2));
        mem_dep = (memrd != 0) && (memrd == rs1 || (reads2 && memrd == rs2));
        if (!ex_dep && !mem_dep) return 0;
        if (br || jr) begin
            if (ex_dep && exmr) return 2;
            if (ex_dep && exrw) return 1;
            if (mem_dep && memmr) return 1;
            return 0;
        end
        return (ex_dep && exmr) ? 1 : 0;
    endfunction

    task automatic test_random();
        int pend, ms_cnt, fl_cnt, need, kind;
        int rs1, rs2, exrd, memrd;
        bit u2, br, jr, tk, exrw, exmr, memmr, ms, r;
        logic [4:0] expv;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        pend = 0; ms_cnt = 0; fl_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            rs1   = $urandom_range(0, 3);
            rs2   = $urandom_range(0, 3);
            exrd  = $urandom_range(0, 3);
            memrd = $urandom_range(0, 3);
            u2    = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 3);
            br    = (kind == 1);
            jr    = (kind == 2);
            tk    = 1'($urandom_range(0, 1));
            exrw  = 1'($urandom_range(0, 1));
            exmr  = 1'($urandom_range(0, 1));
            memmr = 1'($urandom_range(0, 1));
            ms    = ($urandom_range(0, 5) == 0);
            r     = ($urandom_range(0, 499) == 0);
            set_in(5'(rs1), 5'(rs2), u2, br, jr, tk, 5'(exrd), exrw, exmr, 5'(memrd), memmr, ms, r);
            need = need_of(rs1, rs2, u2, br, jr, exrd, exrw, exmr, memrd, memmr);
            if (r)             expv = O_RST;
            else if (ms)       expv = O_FRZ;
            else if (pend > 0) expv = O_STALL;
            else if (need > 0) expv = O_STALL;
            else               expv = tk ? O_FLUSH : O_RUN;
            n_cmp++;
            if (get_out() !== expv) begin
                n_fail++; $display("FAIL rand_out cycle %0d got %b want %b", c, get_out(), expv);
            end
            n_cmp++;
            if (get_cnt() !== exp_cnt(ms_cnt, fl_cnt)) begin
                n_fail++; $display("FAIL rand_cnt cycle %0d got %h want %h", c, get_cnt(), exp_cnt(ms_cnt, fl_cnt));
            end
            if (r) begin
                pend = 0; ms_cnt = 0; fl_cnt = 0;
            end else begin
                if (!ms) begin
                    if (pend > 0)      pend = pend - 1;
                    else if (need > 0) pend = need - 1;
                end
                if ((expv[2] || expv[0]) && ms_cnt < CMAX) ms_cnt++;
                if (expv[1] && fl_cnt < CMAX) fl_cnt++;
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        hif.IF_ID_rs1 = 5'd0; hif.IF_ID_rs2 = 5'd0; hif.use_rs2 = 1'b0;
        hif.branch = 1'b0; hif.jalr = 1'b0; hif.branch_taken = 1'b0;
        hif.ID_EX_rd = 5'd0; hif.ID_EX_regwrite = 1'b0; hif.ID_EX_memread = 1'b0;
        hif.EX_MEM_rd = 5'd0; hif.EX_MEM_memread = 1'b0; hif.mem_stall = 1'b0;
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_freeze();
        test_reset_mid_stall();
        test_perf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
